// File: rtl/goldschmidt_pkg.sv
// Shared types, constants and constant functions for the Goldschmidt divider.
package goldschmidt_pkg;

  localparam int unsigned EW_DEF        = 4;
  localparam int unsigned MW_DEF        = 3;
  localparam int unsigned ITER_DEF      = 3;
  localparam int unsigned GUARD_DEF     = 4;
  localparam int unsigned SEED_BITS_DEF = 3;

  localparam int unsigned FLAG_DBZ = 2;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_UNF = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_N0,
    ST_D0,
    ST_NI,
    ST_DI,
    ST_CORR,
    ST_PACK,
    ST_DONE
  } gs_state_e;

  function automatic int unsigned gs_bias(input int unsigned ew);
    return (32'd1 << (ew - 1)) - 32'd1;
  endfunction

  // Reciprocal of 1.idx (idx on sb bits), truncated to fb fraction bits.
  function automatic int unsigned gs_seed(input int unsigned idx, input int unsigned sb,
                                          input int unsigned fb);
    return (32'd1 << (fb + sb)) / ((32'd1 << sb) + idx);
  endfunction

endpackage

// File: rtl/gs_mul.sv
// Unsigned combinational multiplier shared by every Goldschmidt step.
module gs_mul #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);

  assign p = x * y;

endmodule

// File: rtl/goldschmidt_div_seq.sv
// Sequential Goldschmidt floating-point divider, one shared multiplier, fixed latency.
module goldschmidt_div_seq
  import goldschmidt_pkg::*;
#(
  parameter int unsigned EW        = EW_DEF,
  parameter int unsigned MW        = MW_DEF,
  parameter int unsigned ITER      = ITER_DEF,
  parameter int unsigned GUARD     = GUARD_DEF,
  parameter int unsigned SEED_BITS = SEED_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW+MW:0]  a,
  input  logic [EW+MW:0]  b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+MW:0]  q,
  output logic [2:0]      flags
);

  localparam int unsigned FB   = MW + 1 + GUARD;
  localparam int unsigned W    = FB + 1;
  localparam int unsigned QW   = MW + 2;
  localparam int unsigned EXW  = EW + 2;
  localparam int unsigned BIAS = gs_bias(EW);

  gs_state_e state, state_nx;

  logic [EW+MW:0]   ra, rb;
  logic [W-1:0]     n, d;
  logic [QW-1:0]    qc;
  logic [3:0]       cnt;
  logic             ov;

  logic [W-1:0]     mx, my, x0, f;
  logic [2*W-1:0]   p;
  logic [W-1:0]     seed_rom [2**SEED_BITS];

  logic             sgn, a_zero, b_zero;
  logic [EW-1:0]    ea, eb;
  logic [MW:0]      ma, mb;
  logic [QW-1:0]    qt;
  logic [2*W:0]     rem;
  logic             rem_neg, rem_ge;
  logic [EXW-1:0]   e_raw;
  logic             e_ovf, e_unf;
  logic [MW-1:0]    mant;
  logic [EW+MW:0]   q_nx;
  logic [2:0]       f_nx;

  for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_seed
    assign seed_rom[i] = W'(gs_seed(i, SEED_BITS, FB));
  end

  assign sgn    = ra[EW+MW] ^ rb[EW+MW];
  assign a_zero = (ra[EW+MW-1:0] == '0);
  assign b_zero = (rb[EW+MW-1:0] == '0);
  assign ea     = ra[EW+MW-1:MW];
  assign eb     = rb[EW+MW-1:MW];
  assign ma     = {1'b1, ra[MW-1:0]};
  assign mb     = {1'b1, rb[MW-1:0]};
  assign x0     = seed_rom[rb[MW-1 -: SEED_BITS]];
  assign f      = -d;
  assign qt     = n[W-1:GUARD];

  gs_mul #(.W(W)) u_mul (
    .x (mx),
    .y (my),
    .p (p)
  );

  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      ST_N0:   begin mx = {ma, {(GUARD + 1){1'b0}}}; my = x0; end
      ST_D0:   begin mx = {mb, {(GUARD + 1){1'b0}}}; my = x0; end
      ST_NI:   begin mx = n; my = f; end
      ST_DI:   begin mx = d; my = f; end
      ST_CORR: begin mx = W'(qt); my = W'(mb); end
      default: ;
    endcase
  end

  // qt carries one fraction bit beyond the stored mantissa so that a quotient
  // below 1 still normalises to an exact truncation; the remainder test fixes
  // qt by one ulp in either direction.
  assign rem     = {1'b0, (2*W)'({ma, {(MW + 1){1'b0}}})} - {1'b0, p};
  assign rem_neg = rem[2*W];
  assign rem_ge  = !rem_neg && (rem[2*W-1:0] >= (2*W)'(mb));

  assign e_raw = EXW'(ea) - EXW'(eb) + EXW'(BIAS) - EXW'(!qc[QW-1]);
  assign e_ovf = !e_raw[EXW-1] && (e_raw >= EXW'(2**EW - 1));
  assign e_unf = e_raw[EXW-1] || (e_raw == '0);
  assign mant  = qc[QW-1] ? qc[MW:1] : qc[MW-1:0];

  always_comb begin
    q_nx = '0;
    f_nx = '0;
    if (b_zero) begin
      q_nx           = {sgn, {EW{1'b1}}, {MW{1'b0}}};
      f_nx[FLAG_DBZ] = 1'b1;
    end else if (!a_zero) begin
      if (e_ovf) begin
        q_nx           = {sgn, {EW{1'b1}}, {MW{1'b0}}};
        f_nx[FLAG_OVF] = 1'b1;
      end else if (e_unf) begin
        f_nx[FLAG_UNF] = 1'b1;
      end else begin
        q_nx = {sgn, e_raw[EW-1:0], mant};
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_N0;
      ST_N0:   state_nx = ST_D0;
      ST_D0:   state_nx = ST_NI;
      ST_NI:   state_nx = ST_DI;
      ST_DI:   state_nx = (cnt == 4'(ITER - 1)) ? ST_CORR : ST_NI;
      ST_CORR: state_nx = ST_PACK;
      ST_PACK: state_nx = ST_DONE;
      ST_DONE: if (ov && out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      n     <= '0;
      d     <= '0;
      qc    <= '0;
      cnt   <= '0;
      ov    <= 1'b0;
      q     <= '0;
      flags <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin ra <= a; rb <= b; end
        ST_N0:   begin n <= p[FB +: W]; cnt <= '0; end
        ST_D0:   d <= p[FB +: W];
        ST_NI:   n <= p[FB +: W];
        ST_DI:   begin d <= p[FB +: W]; cnt <= cnt + 4'd1; end
        ST_CORR: qc <= rem_neg ? qt - QW'(1) : (rem_ge ? qt + QW'(1) : qt);
        ST_PACK: begin q <= q_nx; flags <= f_nx; end
        ST_DONE: begin
          if (!ov)            ov <= 1'b1;
          else if (out_ready) ov <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = ov;

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Scoreboard bench for goldschmidt_div_seq with a plain-arithmetic quotient model.
module tb_goldschmidt_div_seq;

  localparam int EW   = 4;
  localparam int MW   = 3;
  localparam int ITER = 3;
  localparam int DW   = 1 + EW + MW;
  localparam int LAT  = 2 * ITER + 5;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] q;
  logic [2:0]    flags;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        stall   = 1'b0;
  logic        rnd_rdy = 1'b0;

  typedef struct {
    logic [DW-1:0] q;
    logic [2:0]    f;
    int unsigned   acc;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] da [7] = '{8'h4C, 8'h38, 8'hCC, 8'h38, 8'h00, 8'h70, 8'h08};
  logic [DW-1:0] db [7] = '{8'h40, 8'h44, 8'h44, 8'h00, 8'h44, 8'h28, 8'h70};
  logic [DW-1:0] dq [7] = '{8'h44, 8'h2A, 8'hC0, 8'h78, 8'h00, 8'h78, 8'h00};
  logic [2:0]    df [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b001};

  goldschmidt_div_seq #(
    .EW(EW), .MW(MW), .ITER(ITER), .GUARD(4), .SEED_BITS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Exact truncated quotient from the field values, no iteration involved.
  function automatic logic [DW+2:0] ref_div(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int ea, eb, ma, mb, e, sig;
    logic s;
    s = x[DW-1] ^ y[DW-1];
    if (y[DW-2:0] == '0) return {s, {EW{1'b1}}, {MW{1'b0}}, 3'b100};
    if (x[DW-2:0] == '0) return '0;
    ea = int'(x[DW-2:MW]);
    eb = int'(y[DW-2:MW]);
    ma = (1 << MW) + int'(x[MW-1:0]);
    mb = (1 << MW) + int'(y[MW-1:0]);
    e  = ea - eb + BIAS;
    if (ma < mb) begin
      e   = e - 1;
      sig = (ma << (MW + 1)) / mb;
    end else begin
      sig = (ma << MW) / mb;
    end
    if (e >= (1 << EW) - 1) return {s, {EW{1'b1}}, {MW{1'b0}}, 3'b010};
    if (e <= 0) return {{DW{1'b0}}, 3'b001};
    return {s, EW'(e), MW'(sig - (1 << MW)), 3'b000};
  endfunction

  // Offers junk while the DUT is busy, then presents the real operands.
  task automatic issue(input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                       input logic [DW+2:0] e);
    int unsigned g = 0;
    exp_t ent;
    while (!in_ready && g < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      a = DW'($urandom);
      b = DW'($urandom);
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b, want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    a = xa;
    b = xb;
    ent.q = e[DW+2:3];
    ent.f = e[2:0];
    ent.acc = cyc + 1;
    sbq.push_back(ent);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : rdy_drv
    forever begin
      @(negedge clk);
      if (stall)        out_ready = 1'b0;
      else if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic prev_ov = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got q=%0h, want no result", q);
        end else begin
          if (!prev_ov) chk("latency", cyc - sbq[0].acc, LAT);
          chk("q", 32'(q), 32'(sbq[0].q));
          chk("flags", 32'(flags), 32'(sbq[0].f));
          if (out_ready) e = sbq.pop_front();
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin : main
    int unsigned g;
    logic ov_seen;
    logic [DW+2:0] r;
    logic [DW-1:0] x, y;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 7; i++) issue(da[i], db[i], {dq[i], df[i]});

    // Back-pressure: hold the result for five cycles.
    g = 0;
    while (sbq.size() != 0 && g < 100) begin @(negedge clk); g++; end
    stall = 1'b1;
    r = ref_div(8'h4C, 8'h44);
    issue(8'h4C, 8'h44, r);
    g = 0;
    while (!out_valid && g < 40) begin @(negedge clk); #2; g++; end
    chk("stall_seen_valid", 32'(out_valid), 32'd1);
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_q", 32'(q), 32'(r[DW+2:3]));
    end
    stall = 1'b0;
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a division.
    @(negedge clk);
    issue(8'h4C, 8'h40, {8'h44, 3'b000});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    sbq.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    chk("midrst_in_ready_hold", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #2;
      if (out_valid) ov_seen = 1'b1;
    end
    chk("midrst_no_out_valid", 32'(ov_seen), 32'd0);
    @(negedge clk);
    issue(8'hCC, 8'h44, {8'hC0, 3'b000});

    // Randomised traffic with random back-pressure and injected zeros.
    rnd_rdy = 1'b1;
    for (int unsigned i = 0; i < 150; i++) begin
      x = DW'($urandom);
      y = DW'($urandom);
      if ($urandom_range(0, 7) == 0) x[DW-2:0] = '0;
      if ($urandom_range(0, 7) == 0) y[DW-2:0] = '0;
      issue(x, y, ref_div(x, y));
    end
    g = 0;
    while (sbq.size() != 0 && g < 300) begin @(negedge clk); g++; end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d, want 0", sbq.size());
    end
    rnd_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/goldschmidt_div_seq.md
GOLDSCHMIDT_DIV_SEQ -- requirements
Module: goldschmidt_div_seq

Interface
REQ-001 SHALL have parameter EW, default 4: exponent field width.
REQ-002 SHALL have parameter MW, default 3: stored mantissa width, with a hidden leading 1.
REQ-003 SHALL have parameter ITER, default 3: number of Goldschmidt refinement iterations, range 1..8.
REQ-004 SHALL have parameter GUARD, default 4: internal fraction guard bits.
REQ-005 SHALL have parameter SEED_BITS, default 3: mantissa MSBs that index the reciprocal seed table.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: operands valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-010 SHALL have port a, input, 1+EW+MW bits: dividend, {sign, biased exponent, mantissa}.
REQ-011 SHALL have port b, input, 1+EW+MW bits: divisor, same format as a.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port q, output, 1+EW+MW bits: quotient.
REQ-015 SHALL have port flags, output, 3 bits: {dbz, ovf, unf}.

Function
REQ-016 SHALL use bias 2^(EW-1)-1; all-zero exponent+mantissa encodes zero; all-ones exponent encodes saturation/infinity.
REQ-017 SHALL capture a and b on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-018 SHALL sequence through IDLE -> N0 -> D0 -> {NI -> DI} x ITER -> CORR -> PACK -> DONE -> IDLE.
REQ-019 SHALL use exactly one shared multiplier, issuing one product per state.
REQ-020 N0/D0 SHALL form N=ma*x0 and D=mb*x0, where x0 comes from the seed table indexed by mb's top SEED_BITS; each NI/DI pair SHALL form F=2-D, N=N*F, D=D*F on MW+1+GUARD fraction bits, truncated.
REQ-021 CORR SHALL truncate N to MW+1 bits giving qt, compute ma-(qt+ulp)*mb, and increment qt when the result is >=0, so q equals the exactly truncated true quotient.
REQ-022 PACK SHALL produce: sign = a.sign^b.sign; exponent = ea-eb+bias, decremented by 1 and mantissa left-shifted when the significand is <1.
REQ-023 out_valid SHALL rise exactly 2*ITER+5 cycles after the accepting edge; this is 11 cycles at defaults.
REQ-024 SHALL hold q and flags stable and keep out_valid high until out_valid && out_ready; the FSM SHALL return to IDLE on the next edge.
REQ-025 Every operand pair, special cases included, SHALL take the same fixed latency.
REQ-026 b==0 SHALL give q={sign, all-ones exponent, 0 mantissa} with dbz=1; a==0 && b==0 SHALL also set dbz.
REQ-027 a==0 with b!=0 SHALL give q=0 and flags=0.
REQ-028 Biased exponent >= 2^EW-1 SHALL give q={sign, all-ones exponent, 0 mantissa} with ovf=1.
REQ-029 Biased exponent <= 0 SHALL give q=0 with unf=1.
REQ-030 in_valid asserted outside IDLE SHALL be ignored and operands SHALL NOT be captured.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, q=0, flags=0, and clear all datapath registers.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight division with no out_valid pulse.
REQ-033 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-034 Shared package goldschmidt_pkg SHALL hold: field-width localparams, the bias function, the FSM state enum, the flag bit indices, and the seed-table function.
REQ-035 Seed table content SHALL be x0 ~ 1/(1.m) truncated to MW+1+GUARD bits.
REQ-036 SHALL instantiate one sub-module gs_mul, an unsigned combinational (MW+2+GUARD)-squared multiplier.
REQ-037 No other sub-modules.

Verification (defaults EW=4, MW=3)
REQ-038 a=0x4C (6.0), b=0x40 (2.0) -> q=0x44 (3.0), flags=0, out_valid exactly 11 cycles after accept.
REQ-039 a=0x38 (1.0), b=0x44 (3.0) -> q=0x2A, flags=0; a=0xCC (-6.0), b=0x44 -> q=0xC0 (-2.0).
REQ-040 a=0x38, b=0x00 -> q=0x78, flags=3'b100; a=0x00, b=0x44 -> q=0x00, flags=0.
REQ-041 a=0x70, b=0x28 -> q=0x78, ovf=1; a=0x08, b=0x70 -> q=0x00, unf=1.
REQ-042 out_ready held low 5 cycles -> q and out_valid stable, in_ready=0; release -> in_ready=1 next cycle.
REQ-043 rst_n pulsed low at cycle 4 of an operation -> out_valid never rises, in_ready=1 while reset is low, next division completes correctly.
